// File: rtl/rs_issue_queue_if.sv
// Entry/writeback types shared by the reservation station and its neighbours,
// plus the dispatch/wakeup/issue bundle seen by the issue queue.
package ooop_types;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [7:0]  opcode;
    logic [5:0]  prd;
    logic        rd_used;
    logic [5:0]  prs1;
    logic        rs1_used;
    logic        prs1_ready;
    logic [5:0]  prs2;
    logic        rs2_used;
    logic        prs2_ready;
    logic [31:0] imm;
  } rs_entry_t;

  typedef struct packed {
    logic       valid;
    logic       rd_used;
    logic [5:0] prd;
  } wb_pkt_t;
endpackage

interface rs_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int N_WB  = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                           in_valid;
  logic                           in_ready;
  ooop_types::rs_entry_t          in_entry;
  ooop_types::wb_pkt_t [N_WB-1:0] wb_bus;
  logic                           issue_valid;
  logic                           issue_ready;
  ooop_types::rs_entry_t          issue_entry;
  logic [CW-1:0]                  count;

  modport master (
    output in_valid, in_entry, wb_bus, issue_ready,
    input  in_ready, issue_valid, issue_entry, count
  );

  modport slave (
    input  in_valid, in_entry, wb_bus, issue_ready,
    output in_ready, issue_valid, issue_entry, count
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Collapsing reservation station: slot 0 is oldest; oldest ready entry is offered combinationally
// from state; wakeup lands at the next edge; dispatch is gated by the registered count only.
module rs_issue_queue #(
  parameter int DEPTH = 8,
  parameter int N_WB  = 3
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  rs_issue_queue_if.slave q
);
  import ooop_types::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  rs_entry_t        slots     [DEPTH];
  rs_entry_t        slots_up  [DEPTH];
  rs_entry_t        slots_nxt [DEPTH];
  rs_entry_t        disp_entry;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    cnt_after;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0]    sel;
  logic             issue_fire;
  logic             disp_fire;

  // Only valid entries absorb wakeups; flags are sticky while resident.
  function automatic rs_entry_t wake(input rs_entry_t e, input wb_pkt_t [N_WB-1:0] wb);
    rs_entry_t r;
    r = e;
    for (int k = 0; k < N_WB; k++) begin
      if (e.valid && wb[k].valid && wb[k].rd_used) begin
        if (wb[k].prd == e.prs1) r.prs1_ready = 1'b1;
        if (wb[k].prd == e.prs2) r.prs2_ready = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    rdy = '0;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = slots[i].valid
             && (!slots[i].rs1_used || slots[i].prs1_ready)
             && (!slots[i].rs2_used || slots[i].prs2_ready);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) sel = IW'(i);
    end
  end

  assign q.in_ready    = (count < CW'(DEPTH));
  assign q.count       = count;
  assign q.issue_valid = |rdy;
  assign q.issue_entry = q.issue_valid ? slots[sel] : '0;
  assign issue_fire    = q.issue_valid && q.issue_ready;
  assign disp_fire     = q.in_valid && q.in_ready;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) slots_up[i] = slots[i + 1];
    slots_up[DEPTH - 1] = '0;

    disp_entry       = q.in_entry;
    disp_entry.valid = 1'b1;

    cnt_after = count - CW'(issue_fire);
    count_nxt = cnt_after + CW'(disp_fire);

    // Slots at or above the issued one collapse down; the newcomer goes just past the survivors.
    for (int i = 0; i < DEPTH; i++) begin
      slots_nxt[i] = wake((issue_fire && i >= int'(sel)) ? slots_up[i] : slots[i], q.wb_bus);
      if (disp_fire && i == int'(cnt_after)) slots_nxt[i] = wake(disp_entry, q.wb_bus);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= slots_nxt[i];
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: issue order, wakeup timing, full/flush/reset behaviour.
module tb_rs_issue_queue;
  import ooop_types::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rs_issue_queue_if #(.DEPTH(8), .N_WB(3)) q ();

  rs_issue_queue #(.DEPTH(8), .N_WB(3)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (q.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_entry_t mk(input logic [5:0] rob,
                                   input logic [5:0] p1, input logic u1, input logic r1,
                                   input logic [5:0] p2, input logic u2, input logic r2);
    rs_entry_t e;
    e            = '0;
    e.rob_idx    = rob;
    e.opcode     = {2'b10, rob};
    e.prd        = rob + 6'd1;
    e.rd_used    = 1'b1;
    e.prs1       = p1;
    e.rs1_used   = u1;
    e.prs1_ready = r1;
    e.prs2       = p2;
    e.rs2_used   = u2;
    e.prs2_ready = r2;
    e.imm        = {rob, rob, rob, rob, rob, 2'b10};
    e.valid      = 1'b0;
    return e;
  endfunction

  function automatic wb_pkt_t wbp(input logic v, input logic u, input logic [5:0] prd);
    wb_pkt_t w;
    w.valid   = v;
    w.rd_used = u;
    w.prd     = prd;
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rs_entry_t a;
    rs_entry_t exp_e;

    q.in_valid    = 1'b0;
    q.in_entry    = '0;
    q.wb_bus      = '0;
    q.issue_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", 128'(q.count), 128'(0));
    check("rst_in_ready", 128'(q.in_ready), 128'(1));
    check("rst_issue_valid", 128'(q.issue_valid), 128'(0));
    check("rst_issue_entry", 128'(q.issue_entry), 128'(0));

    // 1: ready entry issues the cycle after dispatch; fields pass through, valid forced to 1
    a          = mk(6'd1, 6'd2, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0);
    q.in_valid = 1'b1;
    q.in_entry = a;
    check("t1_not_yet", 128'(q.issue_valid), 128'(0));
    tick();
    q.in_valid = 1'b0;
    exp_e       = a;
    exp_e.valid = 1'b1;
    check("t1_count1", 128'(q.count), 128'(1));
    check("t1_issue_valid", 128'(q.issue_valid), 128'(1));
    check("t1_entry", 128'(q.issue_entry), 128'(exp_e));
    tick();
    check("t1_count0", 128'(q.count), 128'(0));
    check("t1_empty", 128'(q.issue_valid), 128'(0));

    // 2: younger ready C bypasses waiting B; B wakes one cycle after WB
    q.in_valid = 1'b1;
    q.in_entry = mk(6'd2, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    q.in_entry = mk(6'd3, 6'd6, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
    check("t2_b_waits", 128'(q.issue_valid), 128'(0));
    tick();
    q.in_valid = 1'b0;
    check("t2_c_first", 128'(q.issue_entry.rob_idx), 128'(3));
    tick();
    check("t2_count_b", 128'(q.count), 128'(1));
    check("t2_b_idle", 128'(q.issue_valid), 128'(0));
    q.wb_bus[1] = wbp(1'b1, 1'b1, 6'd5);
    check("t2_wb_same_cycle", 128'(q.issue_valid), 128'(0));
    tick();
    q.wb_bus = '0;
    check("t2_b_valid", 128'(q.issue_valid), 128'(1));
    check("t2_b_rob", 128'(q.issue_entry.rob_idx), 128'(2));
    check("t2_b_prs1_ready", 128'(q.issue_entry.prs1_ready), 128'(1));
    tick();
    check("t2_drained", 128'(q.count), 128'(0));

    // 3: WB in the dispatch cycle is captured; rd_used=0 / valid=0 WBs do not wake
    q.in_valid  = 1'b1;
    q.in_entry  = mk(6'd4, 6'd7, 1'b1, 1'b1, 6'd9, 1'b1, 1'b0);
    q.wb_bus[0] = wbp(1'b1, 1'b1, 6'd9);
    tick();
    q.in_valid = 1'b0;
    q.wb_bus   = '0;
    check("t3_d_valid", 128'(q.issue_valid), 128'(1));
    check("t3_d_rob", 128'(q.issue_entry.rob_idx), 128'(4));
    check("t3_d_prs2_ready", 128'(q.issue_entry.prs2_ready), 128'(1));
    tick();
    q.in_valid = 1'b1;
    q.in_entry = mk(6'd5, 6'd7, 1'b0, 1'b0, 6'd9, 1'b1, 1'b0);
    tick();
    q.in_valid  = 1'b0;
    q.wb_bus[0] = wbp(1'b1, 1'b0, 6'd9);
    q.wb_bus[1] = wbp(1'b0, 1'b1, 6'd9);
    tick();
    q.wb_bus = '0;
    check("t3_no_wake", 128'(q.issue_valid), 128'(0));
    q.wb_bus[2] = wbp(1'b1, 1'b1, 6'd9);
    tick();
    q.wb_bus = '0;
    check("t3_e_rob", 128'(q.issue_entry.rob_idx), 128'(5));
    tick();
    check("t3_drained", 128'(q.count), 128'(0));

    // 4: fill to DEPTH, in_ready drops; freeing a slot only reopens after count registers
    q.issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q.in_valid = 1'b1;
      q.in_entry = mk(6'(10 + i), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      tick();
    end
    q.in_entry = mk(6'd18, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("t4_full_count", 128'(q.count), 128'(8));
    check("t4_full_in_ready", 128'(q.in_ready), 128'(0));
    check("t4_oldest", 128'(q.issue_entry.rob_idx), 128'(10));
    tick();
    check("t4_stall_stable", 128'(q.issue_entry.rob_idx), 128'(10));
    check("t4_stall_count", 128'(q.count), 128'(8));
    q.issue_ready = 1'b1;
    check("t4_no_credit", 128'(q.in_ready), 128'(0));
    tick();
    check("t4_count7", 128'(q.count), 128'(7));
    check("t4_reopen", 128'(q.in_ready), 128'(1));
    check("t4_next", 128'(q.issue_entry.rob_idx), 128'(11));
    tick();
    q.in_valid = 1'b0;
    check("t4_issue_and_disp", 128'(q.count), 128'(7));
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t4_order%0d", k), 128'(q.issue_entry.rob_idx), 128'(12 + k));
      tick();
    end
    check("t4_drained", 128'(q.count), 128'(0));
    check("t4_empty", 128'(q.issue_valid), 128'(0));

    // 5: issue from slot 1 with a simultaneous dispatch; order must be 22,23,24 then 20
    q.issue_ready = 1'b0;
    q.in_valid    = 1'b1;
    q.in_entry    = mk(6'd20, 6'd20, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    q.in_entry = mk(6'd21, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    q.in_entry = mk(6'd22, 6'd22, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    q.in_entry = mk(6'd23, 6'd23, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    check("t5_sel_slot1", 128'(q.issue_entry.rob_idx), 128'(21));
    q.issue_ready = 1'b1;
    q.in_entry    = mk(6'd24, 6'd24, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    q.in_valid    = 1'b0;
    q.issue_ready = 1'b0;
    check("t5_count", 128'(q.count), 128'(4));
    check("t5_none_ready", 128'(q.issue_valid), 128'(0));
    q.wb_bus[0] = wbp(1'b1, 1'b1, 6'd24);
    q.wb_bus[1] = wbp(1'b1, 1'b1, 6'd23);
    q.wb_bus[2] = wbp(1'b1, 1'b1, 6'd22);
    tick();
    q.wb_bus      = '0;
    q.issue_ready = 1'b1;
    check("t5_first", 128'(q.issue_entry.rob_idx), 128'(22));
    tick();
    check("t5_second", 128'(q.issue_entry.rob_idx), 128'(23));
    tick();
    check("t5_third", 128'(q.issue_entry.rob_idx), 128'(24));
    tick();
    check("t5_oldest_left", 128'(q.count), 128'(1));
    check("t5_oldest_waits", 128'(q.issue_valid), 128'(0));
    q.wb_bus[1] = wbp(1'b1, 1'b1, 6'd20);
    tick();
    q.wb_bus = '0;
    check("t5_last", 128'(q.issue_entry.rob_idx), 128'(20));
    tick();
    check("t5_drained", 128'(q.count), 128'(0));

    // 6: flush beats a same-cycle dispatch
    q.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q.in_valid = 1'b1;
      q.in_entry = mk(6'(30 + i), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      tick();
    end
    check("t6_count5", 128'(q.count), 128'(5));
    q.in_entry = mk(6'd40, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    q.in_valid = 1'b0;
    check("t6_flush_count", 128'(q.count), 128'(0));
    check("t6_flush_issue", 128'(q.issue_valid), 128'(0));
    check("t6_flush_entry", 128'(q.issue_entry), 128'(0));
    tick();
    check("t6_dropped", 128'(q.count), 128'(0));

    // Reset mid-operation discards entries
    q.in_valid = 1'b1;
    q.in_entry = mk(6'd50, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    q.in_valid = 1'b0;
    check("rst2_before", 128'(q.count), 128'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_count", 128'(q.count), 128'(0));
    check("rst2_issue", 128'(q.issue_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
